// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels and the transmitter FSM states.
// The receive path imports this package as well.
package uart_pkg;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_e;
endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/baud_gen.sv
// Free-running bit-period counter; tick is high for the single cycle at count CLK_DIV-1.
// restart pins the count at zero, so the first tick lands CLK_DIV cycles after release.
module baud_gen #(
    parameter int unsigned CLK_DIV = 1667
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int unsigned      CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]    LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so frames can run back to back.
// The line is the LSB of a registered 10-bit shifter, so tx is glitch-free.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1667
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy
);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0]  hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  baud_tick;
    logic                  accept;

    baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .tick    (baud_tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        accept      = bus.tx_valid && tx_ready_q;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = {STOP_BIT, hold_q, START_BIT};
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (baud_tick) begin
                    if (bit_cnt_q < LAST_BIT) begin
                        shift_d   = {LINE_IDLE, shift_q[FRAME_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (hold_full_q) begin
                        // End of stop bit with a byte waiting: chain straight into its start bit.
                        shift_d     = {STOP_BIT, hold_q, START_BIT};
                        hold_full_d = 1'b0;
                        bit_cnt_d   = '0;
                    end else begin
                        shift_d = {FRAME_BITS{LINE_IDLE}};
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx_ready lags hold_full by a cycle, so an accept never meets a transfer edge.
        if (accept) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
        tx_ready_d = !hold_full_q && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= {FRAME_BITS{LINE_IDLE}};
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_ready_q  <= tx_ready_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign tx           = shift_q[0];
    assign busy         = (state_q == SEND) || hold_full_q;
    assign bus.tx_ready = tx_ready_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized bench for uart_tx at CLK_DIV=4; expected line levels come from
// frame arithmetic ({stop, byte, start} held CLK_DIV cycles per bit) and a trace decoder.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int FRAME_CYC = 10 * CLK_DIV;
    localparam int N_RAND    = 200;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;

    uart_tx_if bus ();

    uart_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int check_count;
    int pass_count;
    int fail_count;

    logic       trace[$];
    logic [7:0] sent_q[$];
    int         accepted;
    int         cyc;
    logic       acc_now;
    int         pos;
    int         n_frames;
    int         prev_start;
    logic [7:0] got;
    logic [7:0] exp_b;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        bus.tx_valid = valid;
        bus.tx_data  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level `off` cycles after a frame's start bit began; idle outside the frame.
    function automatic logic line_bit(input logic [7:0] b, input int off);
        logic [9:0] f;
        f = {STOP_BIT, b, START_BIT};
        if (off < 0 || off >= FRAME_CYC) return LINE_IDLE;
        return f[off / CLK_DIV];
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        fail_count  = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00);

        // Reset and idle line.
        repeat (3) step();
        checkOutput("reset_state", {tx, bus.tx_ready, busy}, 3'b110);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            checkOutput($sformatf("idle_c%0d", c), {tx, bus.tx_ready, busy}, 3'b110);
        end

        // Single frame 0xA5 accepted at edge 0.
        applyStimulus(1'b1, 8'hA5);
        step();
        applyStimulus(1'b0, 8'h00);
        checkOutput("a5_c0", {tx, bus.tx_ready, busy}, 3'b101);
        for (int c = 1; c <= 44; c++) begin
            step();
            checkOutput($sformatf("a5_tx_c%0d", c), tx, line_bit(8'hA5, c - 1));
            checkOutput($sformatf("a5_busy_c%0d", c), busy, 1'(c <= 40));
            checkOutput($sformatf("a5_ready_c%0d", c), bus.tx_ready, 1'(c >= 2));
        end

        // 0x55 then 0x0F offered at cycle 2: back-to-back frames.
        applyStimulus(1'b1, 8'h55);
        step();
        applyStimulus(1'b0, 8'h00);
        step();
        step();
        checkOutput("b2b_ready_c2", bus.tx_ready, 1'b1);
        applyStimulus(1'b1, 8'h0F);
        for (int c = 3; c <= 88; c++) begin
            step();
            applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("b2b_tx_c%0d", c), tx,
                        line_bit(8'h55, c - 1) & line_bit(8'h0F, c - 41));
            checkOutput($sformatf("b2b_ready_c%0d", c), bus.tx_ready, 1'(c >= 42));
            checkOutput($sformatf("b2b_busy_c%0d", c), busy, 1'(c <= 80));
        end

        // Valid held high with churning data; only edge-0 and edge-3 values may be sent.
        applyStimulus(1'b1, 8'h11);
        for (int c = 0; c <= 90; c++) begin
            step();
            checkOutput($sformatf("hold_tx_c%0d", c), tx,
                        line_bit(8'h11, c - 1) & line_bit(8'hC3, c - 41));
            checkOutput($sformatf("hold_ready_c%0d", c), bus.tx_ready, 1'((c == 2) || (c >= 42)));
            checkOutput($sformatf("hold_busy_c%0d", c), busy, 1'(c <= 80));
            if (c == 2) applyStimulus(1'b1, 8'hC3);
            else if (c <= 40) applyStimulus(1'b1, 8'($urandom));
            else applyStimulus(1'b0, 8'($urandom));
        end

        // Reset during data bit 4 of 0xFF while 0x00 is held.
        applyStimulus(1'b1, 8'hFF);
        step();
        applyStimulus(1'b0, 8'h00);
        step();
        step();
        applyStimulus(1'b1, 8'h00);
        step();
        applyStimulus(1'b0, 8'h00);
        for (int c = 4; c <= 22; c++) begin
            step();
            checkOutput($sformatf("rst_tx_c%0d", c), tx, line_bit(8'hFF, c - 1));
        end
        checkOutput("rst_busy_before", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst_after", {tx, bus.tx_ready, busy}, 3'b110);
        for (int c = 0; c < 60; c++) begin
            step();
            checkOutput($sformatf("rst_quiet_c%0d", c), {tx, bus.tx_ready, busy}, 3'b110);
        end
        applyStimulus(1'b1, 8'h3C);
        step();
        applyStimulus(1'b0, 8'h00);
        for (int c = 1; c <= 44; c++) begin
            step();
            checkOutput($sformatf("post_rst_tx_c%0d", c), tx, line_bit(8'h3C, c - 1));
            checkOutput($sformatf("post_rst_busy_c%0d", c), busy, 1'(c <= 40));
        end

        // Randomized stream with the producer always valid; line trace decoded afterwards.
        accepted = 0;
        cyc = 0;
        applyStimulus(1'b1, 8'($urandom));
        while (accepted < N_RAND && cyc < N_RAND * FRAME_CYC + 200) begin
            acc_now = bus.tx_valid && bus.tx_ready;
            step();
            cyc++;
            trace.push_back(tx);
            if (acc_now) begin
                sent_q.push_back(bus.tx_data);
                accepted++;
                if (accepted < N_RAND) applyStimulus(1'b1, 8'($urandom));
                else applyStimulus(1'b0, 8'h00);
            end
        end
        checkOutput("rand_accepted", accepted, N_RAND);
        cyc = 0;
        while (busy && cyc < 3 * FRAME_CYC) begin
            step();
            cyc++;
            trace.push_back(tx);
        end
        checkOutput("rand_drain_busy", busy, 1'b0);
        repeat (4) begin
            step();
            trace.push_back(tx);
        end

        pos = 0;
        n_frames = 0;
        prev_start = -1;
        while (pos + FRAME_CYC <= trace.size()) begin
            if (trace[pos] == 1'b0) begin
                for (int b = 0; b < 8; b++) begin
                    got[b] = trace[pos + (b + 1) * CLK_DIV + CLK_DIV / 2];
                end
                checkOutput($sformatf("rand_start_f%0d", n_frames),
                            trace[pos + CLK_DIV / 2], START_BIT);
                checkOutput($sformatf("rand_stop_f%0d", n_frames),
                            trace[pos + 9 * CLK_DIV + CLK_DIV / 2], STOP_BIT);
                if (sent_q.size() > 0) begin
                    exp_b = sent_q.pop_front();
                    checkOutput($sformatf("rand_byte_f%0d", n_frames), got, exp_b);
                end
                if (prev_start >= 0) begin
                    checkOutput($sformatf("rand_period_f%0d", n_frames), pos - prev_start, FRAME_CYC);
                end
                prev_start = pos;
                n_frames++;
                pos += FRAME_CYC;
            end else begin
                pos++;
            end
        end
        checkOutput("rand_frame_count", n_frames, N_RAND);
        checkOutput("rand_unsent_left", sent_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
